ahb_xfer_seq: RTL
=================

Name: ahb_xfer_seq

Overview:
- Request sequencer directly upstream of the AHB master block.
- Walks a source and a destination word region and issues one-cycle re/we requests with next_raddr/next_waddr.
- Captures returned read words into a small FIFO that feeds the edge-detection core, and forwards core results as write data (buffer2_data).
- Exactly one AHB transaction is outstanding at any time.

Parameters:
- ADDR_W, 32, address width of next_raddr/next_waddr/src_base/dst_base.
- DATA_W, 32, word width of all data paths.
- FIFO_DEPTH, 4, read-data FIFO entries (power of 2, >=2).
- ADDR_STEP, 4, byte increment between consecutive words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begin a job (accepted only in IDLE).
- src_base  in  ADDR_W  first read address, sampled on accepted start.
- dst_base  in  ADDR_W  first write address, sampled on accepted start.
- num_words  in  16  words to read and write, sampled on accepted start.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- re  out  1  read request pulse to AHB master.
- we  out  1  write request pulse to AHB master.
- next_raddr  out  ADDR_W  read address to AHB master.
- next_waddr  out  ADDR_W  write address to AHB master.
- buffer2_data  out  DATA_W  write data to AHB master.
- read_complete  in  1  AHB master read finished; rd_data valid this cycle.
- write_complete  in  1  AHB master write finished.
- rd_data  in  DATA_W  read word from AHB master (its hrdata).
- pix_data  out  DATA_W  FIFO head to core.
- pix_valid  out  1  FIFO not empty.
- pix_ready  in  1  core pops head when pix_valid & pix_ready.
- res_data  in  DATA_W  result word from core.
- res_valid  in  1  result offered.
- res_ready  out  1  result holding register empty and busy.

Behaviour:
- Reset (rst high at an edge): state IDLE; busy, done, re, we, pix_valid, res_ready = 0; next_raddr, next_waddr, buffer2_data = 0; FIFO emptied; counters rd_cnt, wr_cnt = 0; holding register empty. Reset mid-job aborts the job silently, with no done pulse.
- States: IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - start with num_words != 0: latch bases and count, go to ARB; busy = 1 from the next cycle.
  - start with num_words == 0: go to FIN (no transfers).
  - start in any other state is ignored.
- ARB priority:
  1. Holding register full and wr_cnt < num_words → WR_REQ.
  2. Otherwise rd_cnt < num_words and (FIFO count + 0) < FIFO_DEPTH → RD_REQ.
  3. Otherwise wr_cnt == num_words → FIN.
  4. Otherwise stay in ARB.
- RD_REQ (1 cycle): re = 1; next_raddr = src_base + ADDR_STEP*rd_cnt, registered and held until the next RD_REQ. Then go to RD_WAIT.
- RD_WAIT: on read_complete, push rd_data, rd_cnt += 1, go to ARB. The read slot is reserved, so the push never overflows.
- WR_REQ (1 cycle): we = 1; next_waddr = dst_base + ADDR_STEP*wr_cnt; buffer2_data = holding register. Both are held stable through WR_WAIT. Then go to WR_WAIT.
- WR_WAIT: on write_complete, empty the holding register, wr_cnt += 1, go to ARB.
- FIN: done = 1 for one cycle, busy = 0 from the next cycle, then IDLE.
- read_complete or write_complete outside its matching WAIT state is ignored, with no state or counter change.
- re and we are never high in the same cycle. Each is high for exactly one cycle per transaction.
- Holding register:
  - Loads res_data when res_valid & res_ready. res_ready = busy & holding register empty.
  - Results offered beyond num_words are not accepted (res_ready = 0 once wr_cnt + full == num_words).
- FIFO:
  - Simultaneous push and pop when full or empty is legal; count is unchanged when full.
  - Pop with pix_ready while empty has no effect.
  - pix_data = head, combinational.
- Address arithmetic is modulo 2^ADDR_W; wrap-around past 0xFFFFFFFF is permitted and not flagged.
- Counters are 16-bit; num_words max 65535.

Test Plan:
- Basic 4-word job: src 0x100, dst 0x200, num 4; AHB model completes 2 cycles after each request; core echoes data XOR 0xFFFFFFFF → re addresses 0x100, 0x104, 0x108, 0x10C; we addresses 0x200–0x20C with inverted data; exactly one done pulse; busy low after.
- Backpressure: pix_ready = 0 → exactly FIFO_DEPTH (4) re pulses, then ARB stalls with no further re. Release pix_ready → remaining reads resume.
- Priority: result already held while FIFO has space → we issued before the next re; re and we never overlap.
- num_words = 0 → done pulses 2 cycles after start; no re/we; busy stays 0 after FIN.
- Spurious completions: read_complete in IDLE and write_complete during RD_WAIT → no counter or FIFO change. start while busy → ignored, bases unchanged.
- Reset mid-job: rst high during WR_WAIT → all outputs 0 next cycle, no done. A new start then runs a 2-word job correctly from rd_cnt = 0.

Source files
------------

// File: rtl/ahb_xfer_seq_if.sv
// Request/response bundle between the transfer sequencer, the AHB master and
// the edge-detection core.
interface ahb_xfer_seq_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] next_raddr;
    logic [ADDR_W-1:0] next_waddr;
    logic [DATA_W-1:0] buffer2_data;
    logic              read_complete;
    logic              write_complete;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output re, we, next_raddr, next_waddr, buffer2_data,
        input  read_complete, write_complete, rd_data,
        output pix_data, pix_valid,
        input  pix_ready,
        input  res_data, res_valid,
        output res_ready
    );

    modport slave (
        input  re, we, next_raddr, next_waddr, buffer2_data,
        output read_complete, write_complete, rd_data,
        input  pix_data, pix_valid,
        output pix_ready,
        output res_data, res_valid,
        input  res_ready
    );
endinterface

// File: rtl/ahb_xfer_seq.sv
// Sequences one-at-a-time AHB read/write requests over a source and destination
// word region, buffering read words for the core and writing back its results.
module ahb_xfer_seq #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [15:0]       num_words,
    output logic              busy,
    output logic              done,
    ahb_xfer_seq_if.master    bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [15:0]       num_q, rd_cnt, wr_cnt;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              re_q, we_q, re_d, we_d, busy_d, done_d;
    logic [ADDR_W-1:0] raddr_q, waddr_q, raddr_d, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              push, pop, wr_done, res_take;

    assign push     = (state_q == RD_WAIT) && bus.read_complete;
    assign wr_done  = (state_q == WR_WAIT) && bus.write_complete;
    assign pop      = bus.pix_ready && (fifo_cnt != '0);
    assign res_take = bus.res_valid && bus.res_ready;

    assign bus.re           = re_q;
    assign bus.we           = we_q;
    assign bus.next_raddr   = raddr_q;
    assign bus.next_waddr   = waddr_q;
    assign bus.buffer2_data = wdata_q;
    assign bus.pix_data     = fifo_mem[rd_ptr];
    assign bus.pix_valid    = (fifo_cnt != '0);
    // Only accept results that still have a destination word left to fill.
    assign bus.res_ready    = busy && !hold_full && (wr_cnt < num_q);

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_words != 16'd0) ? ARB : FIN;
            ARB: begin
                if (hold_full && (wr_cnt < num_q))
                    state_d = WR_REQ;
                else if ((rd_cnt < num_q) && (fifo_cnt < CNT_W'(FIFO_DEPTH)))
                    state_d = RD_REQ;
                else if (wr_cnt == num_q)
                    state_d = FIN;
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: if (bus.read_complete) state_d = ARB;
            WR_REQ:  state_d = WR_WAIT;
            WR_WAIT: if (bus.write_complete) state_d = ARB;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        re_d    = (state_d == RD_REQ);
        we_d    = (state_d == WR_REQ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FIN);
        raddr_d = re_d ? src_q + ADDR_W'(rd_cnt) * ADDR_W'(ADDR_STEP) : raddr_q;
        waddr_d = we_d ? dst_q + ADDR_W'(wr_cnt) * ADDR_W'(ADDR_STEP) : waddr_q;
        wdata_d = we_d ? hold_q : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            we_q    <= we_d;
            busy    <= busy_d;
            done    <= done_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;

            if ((state_q == IDLE) && start) begin
                src_q  <= src_base;
                dst_q  <= dst_base;
                num_q  <= num_words;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
            if (push)    rd_cnt <= rd_cnt + 16'd1;
            if (wr_done) wr_cnt <= wr_cnt + 16'd1;

            // Holding register drains on write completion, refills from the core.
            if (wr_done) begin
                hold_full <= 1'b0;
            end else if (res_take) begin
                hold_q    <= bus.res_data;
                hold_full <= 1'b1;
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Read-data storage needs no reset; occupancy is tracked by fifo_cnt.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.rd_data;
    end
endmodule
